// File: rtl/tick_debouncer_if.sv
// +--------------------------------------------------------------------+
// | tick_debouncer_if                                                  |
// | Button input and debounced event outputs for tick_debouncer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface tick_debouncer_if;
  logic tick;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;
  logic hold_active;
  logic repeat_pulse;

  modport master (
    output tick,
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse,
    input  hold_active,
    input  repeat_pulse
  );

  modport slave (
    input  tick,
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse,
    output hold_active,
    output repeat_pulse
  );
endinterface

`default_nettype wire

// File: rtl/tick_debouncer.sv
// +--------------------------------------------------------------------+
// | tick_debouncer                                                     |
// | Tick-timed push-button debouncer with press/release/long pulses.   |
// | Optional auto-repeat enabled by macro DEBOUNCE_REPEAT_EN.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tick_debouncer #(
  parameter int ACTIVE_LOW       = 1,
  parameter int DEBOUNCE_TICKS   = 10,
  parameter int LONG_PRESS_TICKS = 1000,
  parameter int REPEAT_TICKS     = 200
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  tick_debouncer_if.slave    bus
);

  localparam int c_DCNT_W = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int c_HCNT_W = $clog2(LONG_PRESS_TICKS) + 1;

  localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);
  localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [c_HCNT_W-1:0] c_HCNT_ONE  = c_HCNT_W'(1);
  localparam logic [c_HCNT_W-1:0] c_HCNT_LAST = c_HCNT_W'(LONG_PRESS_TICKS - 1);
  localparam logic [c_HCNT_W-1:0] c_HCNT_MAX  = c_HCNT_W'(LONG_PRESS_TICKS);

  localparam logic c_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS_CHK = 3'd1,
    S_HELD      = 3'd2,
    S_LONG      = 3'd3,
    S_REL_CHK   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_sync0;
  logic                  r_sync1;
  logic                  w_btn_s;
  logic [c_DCNT_W-1:0]   r_dcnt;
  logic [c_HCNT_W-1:0]   r_hcnt;
  logic                  r_was_long;
  logic                  r_btn_level;
  logic                  r_press_pulse;
  logic                  r_release_pulse;
  logic                  r_long_pulse;
  logic                  r_hold_active;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int c_RCNT_W = $clog2(REPEAT_TICKS) + 1;
  localparam logic [c_RCNT_W-1:0] c_RCNT_ONE  = c_RCNT_W'(1);
  localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(REPEAT_TICKS - 1);
  logic [c_RCNT_W-1:0]   r_rcnt;
  logic                  r_repeat_pulse;
`endif

  // Sync flops rest at the released pin level so reset never looks like a press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync0 <= c_RELEASED;
      r_sync1 <= c_RELEASED;
    end else begin
      r_sync0 <= bus.btn_raw;
      r_sync1 <= r_sync0;
    end
  end

  assign w_btn_s = r_sync1 ^ c_RELEASED;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_dcnt          <= '0;
      r_hcnt          <= '0;
      r_was_long      <= 1'b0;
      r_btn_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_hold_active   <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_rcnt          <= '0;
      r_repeat_pulse  <= 1'b0;
`endif
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_repeat_pulse  <= 1'b0;
`endif
      // A button change always takes priority over a coincident tick.
      case (r_state)
        S_IDLE: begin
          if (w_btn_s) begin
            r_state <= S_PRESS_CHK;
            r_dcnt  <= '0;
          end
        end

        S_PRESS_CHK: begin
          if (!w_btn_s) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
          end else if (bus.tick) begin
            if (r_dcnt == c_DCNT_LAST) begin
              r_state       <= S_HELD;
              r_btn_level   <= 1'b1;
              r_press_pulse <= 1'b1;
              r_hcnt        <= '0;
            end else begin
              r_dcnt <= r_dcnt + c_DCNT_ONE;
            end
          end
        end

        S_HELD: begin
          if (!w_btn_s) begin
            r_state    <= S_REL_CHK;
            r_dcnt     <= '0;
            r_was_long <= 1'b0;
          end else if (bus.tick) begin
            if (r_hcnt == c_HCNT_LAST) begin
              r_state       <= S_LONG;
              r_hcnt        <= c_HCNT_MAX;
              r_long_pulse  <= 1'b1;
              r_hold_active <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
              r_rcnt        <= '0;
`endif
            end else begin
              r_hcnt <= r_hcnt + c_HCNT_ONE;
            end
          end
        end

        S_LONG: begin
          if (!w_btn_s) begin
            r_state    <= S_REL_CHK;
            r_dcnt     <= '0;
            r_was_long <= 1'b1;
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (bus.tick) begin
            if (r_rcnt == c_RCNT_LAST) begin
              r_rcnt         <= '0;
              r_repeat_pulse <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + c_RCNT_ONE;
            end
          end
`endif
        end

        S_REL_CHK: begin
          if (w_btn_s) begin
            r_state <= r_was_long ? S_LONG : S_HELD;
          end else if (bus.tick) begin
            if (r_dcnt == c_DCNT_LAST) begin
              r_state         <= S_IDLE;
              r_btn_level     <= 1'b0;
              r_release_pulse <= 1'b1;
              r_hold_active   <= 1'b0;
              r_hcnt          <= '0;
              r_was_long      <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
              r_rcnt          <= '0;
`endif
            end else begin
              r_dcnt <= r_dcnt + c_DCNT_ONE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.btn_level        = r_btn_level;
  assign bus.press_pulse      = r_press_pulse;
  assign bus.release_pulse    = r_release_pulse;
  assign bus.long_press_pulse = r_long_pulse;
  assign bus.hold_active      = r_hold_active;

`ifdef DEBOUNCE_REPEAT_EN
  assign bus.repeat_pulse = r_repeat_pulse;
`else
  logic w_unused_repeat;
  assign w_unused_repeat  = (REPEAT_TICKS < 1);
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_debouncer.sv
// +--------------------------------------------------------------------+
// | tb_tick_debouncer                                                  |
// | Directed bench for tick_debouncer (D=4, L=10, R=3, tick every 5).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_tick_debouncer;

  logic CLK = 1'b0;
  logic RST;

  tick_debouncer_if bus ();

  tick_debouncer #(
    .ACTIVE_LOW      (1),
    .DEBOUNCE_TICKS  (4),
    .LONG_PRESS_TICKS(10),
    .REPEAT_TICKS    (3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  int   tick_cnt   = 0;
  int   n_press    = 0;
  int   n_release  = 0;
  int   n_long     = 0;
  int   n_repeat   = 0;
  int   press_at   = 0;
  int   long_at    = 0;
  int   rep_at     = 0;
  int   bad_timing = 0;
  logic prev_tick  = 1'b0;

  // Tick high for one CLK out of every five, changed shortly after posedge.
  initial begin
    int phase;
    phase    = 0;
    bus.tick = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      phase    = (phase == 4) ? 0 : phase + 1;
      bus.tick = (phase == 4);
    end
  end

  // Each pulse must sit in the cycle right after a tick cycle.
  always @(posedge CLK) begin
    prev_tick <= bus.tick;
    if (bus.tick) tick_cnt <= tick_cnt + 1;
    if (bus.press_pulse) begin
      n_press  <= n_press + 1;
      press_at <= tick_cnt;
      if (!prev_tick) bad_timing <= bad_timing + 1;
    end
    if (bus.release_pulse) begin
      n_release <= n_release + 1;
      if (!prev_tick) bad_timing <= bad_timing + 1;
    end
    if (bus.long_press_pulse) begin
      n_long  <= n_long + 1;
      long_at <= tick_cnt;
      if (!prev_tick) bad_timing <= bad_timing + 1;
    end
    if (bus.repeat_pulse) begin
      n_repeat <= n_repeat + 1;
      rep_at   <= tick_cnt;
      if (!prev_tick) bad_timing <= bad_timing + 1;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Returns at the negedge just after a tick has been consumed.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge CLK); while (!bus.tick);
      @(negedge CLK);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   int'(bus.btn_level),        0);
    check({tag, "_press"},   int'(bus.press_pulse),      0);
    check({tag, "_release"}, int'(bus.release_pulse),    0);
    check({tag, "_long"},    int'(bus.long_press_pulse), 0);
    check({tag, "_hold"},    int'(bus.hold_active),      0);
    check({tag, "_repeat"},  int'(bus.repeat_pulse),     0);
  endtask

  initial begin
    int t0, np, nr, tk;
    RST         = 1'b1;
    bus.btn_raw = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    wait_ticks(3);
    check("idle_no_press", n_press, 0);

    // Clean press
    t0          = tick_cnt;
    bus.btn_raw = 1'b0;
    wait_ticks(3);
    check("press_not_early", int'(bus.btn_level), 0);
    wait_ticks(1);
    check("press_pulse", int'(bus.press_pulse), 1);
    check("press_level", int'(bus.btn_level), 1);
    @(negedge CLK);
    check("press_one_clk", int'(bus.press_pulse), 0);
    check("press_tick", press_at, t0 + 4);
    check("press_no_rel", n_release, 0);
    check("press_no_long", n_long, 0);

    // Long press and repeat
    wait_ticks(9);
    check("long_not_early", int'(bus.long_press_pulse), 0);
    check("hold_not_early", int'(bus.hold_active), 0);
    wait_ticks(1);
    check("long_pulse", int'(bus.long_press_pulse), 1);
    check("long_hold", int'(bus.hold_active), 1);
    wait_ticks(10);
    check("long_once", n_long, 1);
`ifdef DEBOUNCE_REPEAT_EN
    check("repeat_count", n_repeat, 3);
    check("repeat_last", rep_at, long_at + 9);
`else
    check("repeat_count", n_repeat, 0);
`endif

    // Release from LONG
    bus.btn_raw = 1'b1;
    wait_ticks(3);
    check("rel_level_held", int'(bus.btn_level), 1);
    check("rel_hold_held", int'(bus.hold_active), 1);
    wait_ticks(1);
    check("rel_pulse", int'(bus.release_pulse), 1);
    check("rel_level", int'(bus.btn_level), 0);
    check("rel_hold", int'(bus.hold_active), 0);
    @(negedge CLK);
    check("rel_count", n_release, 1);

    // Bounce: two ticks low, one CLK high, three times
    np = n_press;
    repeat (3) begin
      bus.btn_raw = 1'b0;
      wait_ticks(2);
      bus.btn_raw = 1'b1;
      @(negedge CLK);
    end
    wait_ticks(6);
    check("bounce_no_press", n_press, np);
    check("bounce_level", int'(bus.btn_level), 0);

    // Release glitch during HELD at hcnt=5
    bus.btn_raw = 1'b0;
    wait_ticks(4);
    check("glitch_press", int'(bus.press_pulse), 1);
    nr = n_release;
    wait_ticks(5);
    bus.btn_raw = 1'b1;
    wait_ticks(2);
    check("glitch_level", int'(bus.btn_level), 1);
    bus.btn_raw = 1'b0;
    wait_ticks(4);
    check("glitch_long_early", int'(bus.long_press_pulse), 0);
    wait_ticks(1);
    check("glitch_long", int'(bus.long_press_pulse), 1);
    check("glitch_no_rel", n_release, nr);
    bus.btn_raw = 1'b1;
    wait_ticks(5);
    check("glitch_rel", n_release, nr + 1);

    // Reset while HELD with the button still down
    bus.btn_raw = 1'b0;
    wait_ticks(4);
    check("rst_pre_press", int'(bus.press_pulse), 1);
    wait_ticks(3);
    np  = n_press;
    nr  = n_release;
    tk  = tick_cnt;
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("rst_during");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_after_level", int'(bus.btn_level), 0);
    for (int i = 0; i < 60 && n_press == np; i++) @(negedge CLK);
    check("rst_repress", n_press, np + 1);
    check("rst_repress_tick", press_at, tk + 5);
    check("rst_no_rel", n_release, nr);
    check("pulse_timing", bad_timing, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
